// File: rtl/exec_issue_arbiter.sv
// Round-robin arbiter that shares one execution unit between NUM_REQ requesters:
// grant, operand capture, issue, bounded wait for the result, and routed response.
module exec_issue_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [7*NUM_REQ-1:0]          req_opcode,
  input  logic [3*NUM_REQ-1:0]          req_funct3,
  input  logic [7*NUM_REQ-1:0]          req_funct7,
  input  logic [21*NUM_REQ-1:0]         req_imm,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_src1,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_src2,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_error,
  output logic                          busy,
  input  logic                          system_stall,
  output logic [6:0]                    eu_instruction_type,
  output logic [2:0]                    eu_funct3,
  output logic [6:0]                    eu_funct7,
  output logic [20:0]                   eu_immediate,
  output logic [DATA_WIDTH-1:0]         eu_data_src1,
  output logic [DATA_WIDTH-1:0]         eu_data_src2,
  output logic                          eu_system_stall,
  input  logic [DATA_WIDTH-1:0]         eu_result,
  input  logic                          eu_result_valid,
  output logic [1:0]                    dbg_state
);

  // Handshake: a request is accepted in the cycle where req_valid[i] and req_ready[i]
  // are both high; requesters keep req_* stable until then. rsp_valid is a one-cycle
  // strobe with no back-pressure.

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_rr;
  logic [IW-1:0]         r_grant;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         w_pick;
  logic [IW:0]           w_idx;
  logic                  w_any;
  logic                  w_grant_ok;
  logic                  w_timeout;
  logic [6:0]            r_eu_op;
  logic [2:0]            r_eu_f3;
  logic [6:0]            r_eu_f7;
  logic [20:0]           r_eu_imm;
  logic [DATA_WIDTH-1:0] r_eu_src1;
  logic [DATA_WIDTH-1:0] r_eu_src2;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_error;

  // First valid requester at or above the rr pointer, wrapping around.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr} + (IW+1)'(i);
      if (w_idx >= (IW+1)'(NUM_REQ)) w_idx = w_idx - (IW+1)'(NUM_REQ);
      if (!w_any && req_valid[w_idx[IW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[IW-1:0];
      end
    end
  end

  assign w_grant_ok = reset && (r_state == S_IDLE) && !system_stall && w_any;
  assign w_timeout  = (r_state == S_WAIT) && !eu_result_valid && !system_stall &&
                      (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_ok) w_next = S_ISSUE;
      S_ISSUE: if (!system_stall) w_next = S_WAIT;
      S_WAIT:  if (eu_result_valid || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_eu_op     <= '0;
      r_eu_f3     <= '0;
      r_eu_f7     <= '0;
      r_eu_imm    <= '0;
      r_eu_src1   <= '0;
      r_eu_src2   <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_grant_ok) begin
            r_grant   <= w_pick;
            r_eu_op   <= req_opcode[w_pick*7 +: 7];
            r_eu_f3   <= req_funct3[w_pick*3 +: 3];
            r_eu_f7   <= req_funct7[w_pick*7 +: 7];
            r_eu_imm  <= req_imm[w_pick*21 +: 21];
            r_eu_src1 <= req_src1[w_pick*DATA_WIDTH +: DATA_WIDTH];
            r_eu_src2 <= req_src2[w_pick*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_WAIT: begin
          // A result arriving on the timeout cycle takes priority over the abort.
          if (eu_result_valid) begin
            r_rsp_data  <= eu_result;
            r_rsp_error <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
          end else if (!system_stall) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_rr      <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);
          r_cnt     <= '0;
          r_eu_op   <= '0;
          r_eu_f3   <= '0;
          r_eu_f7   <= '0;
          r_eu_imm  <= '0;
          r_eu_src1 <= '0;
          r_eu_src2 <= '0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready           = w_grant_ok ? (NUM_REQ'(1) << w_pick) : '0;
  assign rsp_valid           = (r_state == S_RESP) ? (NUM_REQ'(1) << r_grant) : '0;
  assign rsp_data            = r_rsp_data;
  assign rsp_error           = r_rsp_error;
  assign busy                = (r_state != S_IDLE);
  assign dbg_state           = r_state;
  assign eu_instruction_type = r_eu_op;
  assign eu_funct3           = r_eu_f3;
  assign eu_funct7           = r_eu_f7;
  assign eu_immediate        = r_eu_imm;
  assign eu_data_src1        = r_eu_src1;
  assign eu_data_src2        = r_eu_src2;
  assign eu_system_stall     = system_stall;

endmodule

// File: tb/tb_exec_issue_arbiter.sv
// Directed bench for exec_issue_arbiter: arbitration order, latency, timeout,
// stall handling, mid-operation reset and stray EU strobes.
module tb_exec_issue_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam logic [6:0] OP = 7'h33;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [7*NR-1:0]  req_opcode;
  logic [3*NR-1:0]  req_funct3;
  logic [7*NR-1:0]  req_funct7;
  logic [21*NR-1:0] req_imm;
  logic [DW*NR-1:0] req_src1;
  logic [DW*NR-1:0] req_src2;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_error;
  logic             busy;
  logic             system_stall;
  logic [6:0]       eu_instruction_type;
  logic [2:0]       eu_funct3;
  logic [6:0]       eu_funct7;
  logic [20:0]      eu_immediate;
  logic [DW-1:0]    eu_data_src1;
  logic [DW-1:0]    eu_data_src2;
  logic             eu_system_stall;
  logic [DW-1:0]    eu_result;
  logic             eu_result_valid;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  exec_issue_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_imm(req_imm), .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy),
    .system_stall(system_stall),
    .eu_instruction_type(eu_instruction_type), .eu_funct3(eu_funct3),
    .eu_funct7(eu_funct7), .eu_immediate(eu_immediate),
    .eu_data_src1(eu_data_src1), .eu_data_src2(eu_data_src2),
    .eu_system_stall(eu_system_stall),
    .eu_result(eu_result), .eu_result_valid(eu_result_valid),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // EU behavioural model: the operation the bench expects the EU to perform.
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] a, input logic [31:0] b);
    if (f3 == 3'd0) return (f7 == 7'h20) ? a - b : a + b;
    else if (f3 == 3'd7) return a & b;
    else return 32'hDEAD_BEEF;
  endfunction

  // Driver tasks: inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic set_req(input int r, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [20:0] imm, input logic [31:0] a, input logic [31:0] b);
    req_opcode[r*7 +: 7]   = OP;
    req_funct3[r*3 +: 3]   = f3;
    req_funct7[r*7 +: 7]   = f7;
    req_imm[r*21 +: 21]    = imm;
    req_src1[r*DW +: DW]   = a;
    req_src2[r*DW +: DW]   = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits (bounded) for a grant in the current IDLE cycle, checks it, ends in ISSUE.
  task automatic grant_wait(input logic [1:0] exp, input string tag);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'(exp));
    @(negedge clk);
  endtask

  task automatic eu_pulse(input logic [31:0] val);
    eu_result       = val;
    eu_result_valid = 1'b1;
    @(negedge clk);
    eu_result_valid = 1'b0;
    eu_result       = '0;
  endtask

  // Strobes the EU result k cycles from now, computed from what the EU was handed.
  task automatic eu_reply(input int k);
    repeat (k) @(negedge clk);
    eu_pulse(alu(eu_funct3, eu_funct7, eu_data_src1, eu_data_src2));
  endtask

  task automatic expect_rsp(input logic [1:0] ev, input logic [31:0] ed, input logic ee,
                            input string tag);
    #1;
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(ev));
    check({tag, "_rsp_data"},  64'(rsp_data),  64'(ed));
    check({tag, "_rsp_error"}, 64'(rsp_error), 64'(ee));
    @(negedge clk);
    #1;
    check({tag, "_rsp_once"},  64'(rsp_valid), 64'(0));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_idle_eu"},   64'(eu_data_src1), 64'(0));
  endtask

  task automatic wait_rsp(input int exp_n, input logic [1:0] ev, input logic [31:0] ed,
                          input logic ee, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rsp_valid == '0 && n < 100);
    check({tag, "_latency"}, 64'(n), 64'(exp_n));
    expect_rsp(ev, ed, ee, tag);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
    req_imm = '0; req_src1 = '0; req_src2 = '0; system_stall = 1'b0;
    eu_result = '0; eu_result_valid = 1'b0;

    // Reset state, with a request pending that must not be acknowledged
    req_valid = 2'b01;
    @(negedge clk); #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_eu_type", 64'(eu_instruction_type), 64'(0));
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;

    // 1: single ADD, EU answers 2 cycles after ISSUE
    set_req(0, 3'd0, 7'h00, 21'h155, 32'h10, 32'h20);
    req_valid = 2'b01;
    grant_wait(2'b01, "t1");
    req_valid = '0;
    #1;
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_state_issue", 64'(dbg_state), 64'(1));
    check("t1_eu_type", 64'(eu_instruction_type), 64'(OP));
    check("t1_eu_src1", 64'(eu_data_src1), 64'(32'h10));
    check("t1_eu_src2", 64'(eu_data_src2), 64'(32'h20));
    check("t1_eu_imm", 64'(eu_immediate), 64'(21'h155));
    eu_reply(2);
    expect_rsp(2'b01, 32'h30, 1'b0, "t1");

    // 2: both requesters held valid, strict alternation starting at req0
    do_reset();
    set_req(0, 3'd0, 7'h20, 21'h0, 32'h30, 32'h10);
    set_req(1, 3'd7, 7'h00, 21'h0, 32'hFFFF_FFF0, 32'h0F0F_0F0F);
    req_valid = 2'b11;
    grant_wait(2'b01, "t2a"); eu_reply(1); expect_rsp(2'b01, 32'h20, 1'b0, "t2a");
    grant_wait(2'b10, "t2b"); eu_reply(3); expect_rsp(2'b10, 32'h0F0F_0F00, 1'b0, "t2b");
    grant_wait(2'b01, "t2c"); eu_reply(1); expect_rsp(2'b01, 32'h20, 1'b0, "t2c");
    req_valid = '0;

    // 3: silent EU times out after 15 WAIT cycles
    set_req(0, 3'd0, 7'h00, 21'h0, 32'd1, 32'd2);
    req_valid = 2'b01;
    grant_wait(2'b01, "t3");
    req_valid = '0;
    wait_rsp(16, 2'b01, 32'h0, 1'b1, "t3_timeout");

    // Strobe during ISSUE is ignored; first-WAIT strobe gives minimum latency
    set_req(1, 3'd0, 7'h00, 21'h0, 32'd5, 32'd6);
    req_valid = 2'b10;
    grant_wait(2'b10, "t3b");
    req_valid = '0;
    eu_pulse(32'hBAD0_BAD0);
    #1;
    check("t3b_issue_ignored", 64'(dbg_state), 64'(2));
    check("t3b_no_rsp", 64'(rsp_valid), 64'(0));
    eu_reply(0);
    expect_rsp(2'b10, 32'hB, 1'b0, "t3b");

    // Result on the 15th WAIT cycle beats the timeout
    set_req(0, 3'd0, 7'h20, 21'h0, 32'd100, 32'd1);
    req_valid = 2'b01;
    grant_wait(2'b01, "t3c");
    req_valid = '0;
    eu_reply(15);
    expect_rsp(2'b01, 32'd99, 1'b0, "t3c");

    // 4: 5 stalled cycles in WAIT stretch the timeout to 20 WAIT cycles
    set_req(0, 3'd0, 7'h00, 21'h0, 32'd3, 32'd4);
    req_valid = 2'b01;
    grant_wait(2'b01, "t4");
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    system_stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t4_eu_stall", 64'(eu_system_stall), 64'(1));
    check("t4_state_wait", 64'(dbg_state), 64'(2));
    check("t4_no_rsp", 64'(rsp_valid), 64'(0));
    repeat (3) @(negedge clk);
    system_stall = 1'b0;
    wait_rsp(14, 2'b01, 32'h0, 1'b1, "t4_timeout");

    // Stall in IDLE blocks the grant
    set_req(0, 3'd7, 7'h00, 21'h0, 32'hF0, 32'h3C);
    system_stall = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4b_stall_ready", 64'(req_ready), 64'(0));
      check("t4b_stall_busy", 64'(busy), 64'(0));
      @(negedge clk);
    end
    system_stall = 1'b0;
    grant_wait(2'b01, "t4b");
    req_valid = '0;
    eu_reply(1);
    expect_rsp(2'b01, 32'h30, 1'b0, "t4b");

    // 5: reset during WAIT drops the op; afterwards req0 has priority again
    set_req(1, 3'd0, 7'h00, 21'h0, 32'd7, 32'd8);
    req_valid = 2'b10;
    grant_wait(2'b10, "t5");
    req_valid = '0;
    @(negedge clk);
    #1;
    check("t5_state_wait", 64'(dbg_state), 64'(2));
    #1;
    reset = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_state", 64'(dbg_state), 64'(0));
    check("t5_rst_eu_src1", 64'(eu_data_src1), 64'(0));
    check("t5_rst_eu_type", 64'(eu_instruction_type), 64'(0));
    check("t5_rst_rsp_data", 64'(rsp_data), 64'(0));
    check("t5_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    set_req(0, 3'd0, 7'h20, 21'h0, 32'd100, 32'd1);
    req_valid = 2'b11;
    #1;
    check("t5_rst_ready", 64'(req_ready), 64'(0));
    eu_pulse(32'h15);
    reset = 1'b1;
    grant_wait(2'b01, "t5b");
    req_valid = '0;
    #1;
    check("t5b_no_stale_rsp", 64'(rsp_valid), 64'(0));
    eu_reply(2);
    expect_rsp(2'b01, 32'd99, 1'b0, "t5b");

    // 6: stray EU strobe in IDLE
    eu_pulse(32'h77);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_no_rsp", 64'(rsp_valid), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
